execute_stage: RTL and testbench
================================

Name: execute_stage

Overview:
- EX stage of the 5-stage LEGv8 pipeline, directly downstream of InstructionDecode.
- Consumes the ID/EX bundle: controls, register operands, sign-extended immediate and PC.
- Performs the ALU operation, computes the branch target and the branch-taken decision, then registers everything into the EX/MEM pipeline register.
- Supports stall (hold) and flush (bubble insertion) from the hazard unit.

Parameters:
- DW, 64, datapath width
- RW, 5, register-index width

Ports:
- clk  in  1  rising-edge clock
- resetl  in  1  asynchronous active-low reset
- stall_EX  in  1  hold EX/MEM register contents
- flush_EX  in  1  replace incoming instruction with bubble
- RegWrite_EX, ALUSrc_EX, Branch_EX, Uncondbranch_EX, MemRead_EX, MemWrite_EX, Mem2Reg_EX  in  1 each  controls from ID
- ALUOp_EX  in  4  ALU operation select
- RD_EX  in  RW  destination register
- RegOutA_EX, RegOutB_EX  in  DW  register operands
- SignExtImm64_EX  in  DW  sign-extended immediate
- pc_EX  in  DW  PC of the instruction
- RegWrite_MEM, Branch_MEM, Uncondbranch_MEM, MemRead_MEM, MemWrite_MEM, Mem2Reg_MEM  out  1 each  registered controls
- BranchTaken_MEM  out  1  registered branch/jump decision
- Zero_MEM  out  1  registered ALU zero flag
- ALUResult_MEM  out  DW  registered ALU result (memory address for LDUR/STUR)
- WriteData_MEM  out  DW  registered RegOutB_EX (store data)
- BranchTarget_MEM  out  DW  registered pc_EX + (SignExtImm64_EX << 2)
- RD_MEM  out  RW  registered destination
- pc_MEM  out  DW  registered pc_EX

Behaviour:
- Reset: clk and resetl as stated above; reset is asynchronous and active-low. On resetl=0, all outputs clear to 0 immediately, independent of clk. Deassertion takes effect at the next rising edge.
- ALU operand B selection (combinational): B = ALUSrc_EX ? SignExtImm64_EX : RegOutB_EX.
- ALUOp decode:
  - 0000: A & B
  - 0001: A | B
  - 0010: A + B
  - 0110: A - B
  - 0111: pass B (CBZ test)
  - any other code: result 0
- Arithmetic is modulo 2^DW; overflow is silently discarded and no flags are produced.
- Zero = (result == 0).
- BranchTarget = pc_EX + (SignExtImm64_EX << 2), modulo 2^DW; a negative offset wraps correctly (two's complement).
- BranchTaken = Uncondbranch_EX | (Branch_EX & Zero).
- Latency: exactly 1 cycle. Inputs sampled at rising edge N appear on the *_MEM outputs after edge N.
- Normal edge (no stall, no flush): all *_MEM registers load the computed values.
- stall_EX=1, flush_EX=0: every *_MEM register holds its current value. Inputs are ignored that cycle.
- flush_EX=1 (regardless of stall_EX): load a bubble.
  - RegWrite, MemRead, MemWrite, Mem2Reg, Branch, Uncondbranch, BranchTaken all become 0.
  - Datapath fields (ALUResult, WriteData, BranchTarget, RD, pc, Zero) become 0.
  - Flush has priority over stall.
- A bubble must never produce a memory access, a register write or a redirect.
- Reset asserted mid-stall or mid-flush: the reset wins asynchronously. After reset deassertion the first edge loads normally.
- RD=31 (XZR) passes through unchanged; suppressing writes to XZR is the register file's job.

Test Plan:
- ADD: RegOutA=5, RegOutB=7, ALUSrc=0, ALUOp=0010, RD=3, RegWrite=1 -> after one edge ALUResult_MEM=12, Zero_MEM=0, RD_MEM=3, RegWrite_MEM=1, BranchTaken_MEM=0.
- LDUR address and SUB zero flag:
  - LDUR: A=0x100, Imm=0x8, ALUSrc=1, ALUOp=0010, MemRead=1, Mem2Reg=1 -> ALUResult_MEM=0x108, MemRead_MEM=1.
  - SUB: A=B=9, ALUOp=0110 -> ALUResult_MEM=0, Zero_MEM=1.
- CBZ backward branch: pc_EX=0x40, Imm=-4 (0xFFFF_FFFF_FFFF_FFFC), RegOutB=0, ALUOp=0111, Branch=1 -> BranchTarget_MEM=0x30, Zero_MEM=1, BranchTaken_MEM=1. Repeat with RegOutB=1 -> BranchTaken_MEM=0.
- B: Uncondbranch=1, pc_EX=8, Imm=3 -> BranchTarget_MEM=0x14, BranchTaken_MEM=1.
- Stall/flush priority:
  - Load ADD result 12, then assert stall_EX for 2 cycles with new inputs (ORR A=1, B=2) -> outputs stay 12.
  - Deassert stall -> ALUResult_MEM=3.
  - Assert stall_EX and flush_EX together with MemWrite=1 -> all controls 0 and ALUResult_MEM=0.
- Async reset: with RegWrite_MEM=1, drop resetl between clock edges -> all outputs 0 before the next edge. Raise resetl -> next edge loads the current inputs.

Source files
------------

// File: rtl/execute_stage.sv
// LEGv8 EX stage: ALU, branch target and branch decision, followed by the
// EX/MEM pipeline register with hold (stall) and bubble (flush) control.
module execute_stage #(
  parameter int unsigned DW = 64,
  parameter int unsigned RW = 5
) (
  input  logic          clk,
  input  logic          resetl,
  input  logic          stall_EX,
  input  logic          flush_EX,
  input  logic          RegWrite_EX,
  input  logic          ALUSrc_EX,
  input  logic          Branch_EX,
  input  logic          Uncondbranch_EX,
  input  logic          MemRead_EX,
  input  logic          MemWrite_EX,
  input  logic          Mem2Reg_EX,
  input  logic [3:0]    ALUOp_EX,
  input  logic [RW-1:0] RD_EX,
  input  logic [DW-1:0] RegOutA_EX,
  input  logic [DW-1:0] RegOutB_EX,
  input  logic [DW-1:0] SignExtImm64_EX,
  input  logic [DW-1:0] pc_EX,
  output logic          RegWrite_MEM,
  output logic          Branch_MEM,
  output logic          Uncondbranch_MEM,
  output logic          MemRead_MEM,
  output logic          MemWrite_MEM,
  output logic          Mem2Reg_MEM,
  output logic          BranchTaken_MEM,
  output logic          Zero_MEM,
  output logic [DW-1:0] ALUResult_MEM,
  output logic [DW-1:0] WriteData_MEM,
  output logic [DW-1:0] BranchTarget_MEM,
  output logic [RW-1:0] RD_MEM,
  output logic [DW-1:0] pc_MEM
);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_ORR  = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_PASS = 4'b0111;

  logic [DW-1:0] alu_b;
  logic [DW-1:0] alu_res;
  logic [DW-1:0] br_tgt;
  logic          alu_zero;
  logic          br_taken;

  // ALU with operand-B mux; undefined opcodes yield zero
  always_comb begin
    alu_b   = ALUSrc_EX ? SignExtImm64_EX : RegOutB_EX;
    alu_res = '0;
    case (ALUOp_EX)
      OP_AND:  alu_res = RegOutA_EX & alu_b;
      OP_ORR:  alu_res = RegOutA_EX | alu_b;
      OP_ADD:  alu_res = RegOutA_EX + alu_b;
      OP_SUB:  alu_res = RegOutA_EX - alu_b;
      OP_PASS: alu_res = alu_b;
      default: alu_res = '0;
    endcase
  end

  assign alu_zero = (alu_res == '0);
  assign br_tgt   = pc_EX + {SignExtImm64_EX[DW-3:0], 2'b00};
  assign br_taken = Uncondbranch_EX | (Branch_EX & alu_zero);

  logic          reg_write_q, reg_write_d;
  logic          branch_q, branch_d;
  logic          uncond_q, uncond_d;
  logic          mem_read_q, mem_read_d;
  logic          mem_write_q, mem_write_d;
  logic          mem2reg_q, mem2reg_d;
  logic          taken_q, taken_d;
  logic          zero_q, zero_d;
  logic [DW-1:0] alu_q, alu_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] tgt_q, tgt_d;
  logic [RW-1:0] rd_q, rd_d;
  logic [DW-1:0] pc_q, pc_d;

  // Next-state: flush inserts an all-zero bubble and outranks stall
  always_comb begin
    reg_write_d = reg_write_q;
    branch_d    = branch_q;
    uncond_d    = uncond_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    mem2reg_d   = mem2reg_q;
    taken_d     = taken_q;
    zero_d      = zero_q;
    alu_d       = alu_q;
    wdata_d     = wdata_q;
    tgt_d       = tgt_q;
    rd_d        = rd_q;
    pc_d        = pc_q;
    if (flush_EX) begin
      reg_write_d = 1'b0;
      branch_d    = 1'b0;
      uncond_d    = 1'b0;
      mem_read_d  = 1'b0;
      mem_write_d = 1'b0;
      mem2reg_d   = 1'b0;
      taken_d     = 1'b0;
      zero_d      = 1'b0;
      alu_d       = '0;
      wdata_d     = '0;
      tgt_d       = '0;
      rd_d        = '0;
      pc_d        = '0;
    end else if (!stall_EX) begin
      reg_write_d = RegWrite_EX;
      branch_d    = Branch_EX;
      uncond_d    = Uncondbranch_EX;
      mem_read_d  = MemRead_EX;
      mem_write_d = MemWrite_EX;
      mem2reg_d   = Mem2Reg_EX;
      taken_d     = br_taken;
      zero_d      = alu_zero;
      alu_d       = alu_res;
      wdata_d     = RegOutB_EX;
      tgt_d       = br_tgt;
      rd_d        = RD_EX;
      pc_d        = pc_EX;
    end
  end

  always_ff @(posedge clk or negedge resetl) begin
    if (!resetl) begin
      reg_write_q <= 1'b0;
      branch_q    <= 1'b0;
      uncond_q    <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem2reg_q   <= 1'b0;
      taken_q     <= 1'b0;
      zero_q      <= 1'b0;
      alu_q       <= '0;
      wdata_q     <= '0;
      tgt_q       <= '0;
      rd_q        <= '0;
      pc_q        <= '0;
    end else begin
      reg_write_q <= reg_write_d;
      branch_q    <= branch_d;
      uncond_q    <= uncond_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      mem2reg_q   <= mem2reg_d;
      taken_q     <= taken_d;
      zero_q      <= zero_d;
      alu_q       <= alu_d;
      wdata_q     <= wdata_d;
      tgt_q       <= tgt_d;
      rd_q        <= rd_d;
      pc_q        <= pc_d;
    end
  end

  assign RegWrite_MEM     = reg_write_q;
  assign Branch_MEM       = branch_q;
  assign Uncondbranch_MEM = uncond_q;
  assign MemRead_MEM      = mem_read_q;
  assign MemWrite_MEM     = mem_write_q;
  assign Mem2Reg_MEM      = mem2reg_q;
  assign BranchTaken_MEM  = taken_q;
  assign Zero_MEM         = zero_q;
  assign ALUResult_MEM    = alu_q;
  assign WriteData_MEM    = wdata_q;
  assign BranchTarget_MEM = tgt_q;
  assign RD_MEM           = rd_q;
  assign pc_MEM           = pc_q;

endmodule

// File: tb/tb_execute_stage.sv
// Bench for execute_stage: directed LEGv8 cases plus randomized traffic,
// every cycle checked against a behavioural model of the EX/MEM register.
module tb_execute_stage;

  typedef struct packed {
    logic        rw, br, ub, mr, mw, m2r, bt, z;
    logic [63:0] alu, wd, tgt;
    logic [4:0]  rd;
    logic [63:0] pc;
  } out_t;

  logic        clk, resetl, stall, flush;
  logic        rw_i, src_i, br_i, ub_i, mr_i, mw_i, m2r_i;
  logic [3:0]  op_i;
  logic [4:0]  rd_i;
  logic [63:0] a_i, b_i, imm_i, pc_i;

  logic        rw_o, br_o, ub_o, mr_o, mw_o, m2r_o, bt_o, z_o;
  logic [63:0] alu_o, wd_o, tgt_o, pc_o;
  logic [4:0]  rd_o;

  out_t act, exp_q;
  int   checks, failures;

  execute_stage dut (
    .clk(clk), .resetl(resetl), .stall_EX(stall), .flush_EX(flush),
    .RegWrite_EX(rw_i), .ALUSrc_EX(src_i), .Branch_EX(br_i),
    .Uncondbranch_EX(ub_i), .MemRead_EX(mr_i), .MemWrite_EX(mw_i),
    .Mem2Reg_EX(m2r_i), .ALUOp_EX(op_i), .RD_EX(rd_i),
    .RegOutA_EX(a_i), .RegOutB_EX(b_i), .SignExtImm64_EX(imm_i), .pc_EX(pc_i),
    .RegWrite_MEM(rw_o), .Branch_MEM(br_o), .Uncondbranch_MEM(ub_o),
    .MemRead_MEM(mr_o), .MemWrite_MEM(mw_o), .Mem2Reg_MEM(m2r_o),
    .BranchTaken_MEM(bt_o), .Zero_MEM(z_o), .ALUResult_MEM(alu_o),
    .WriteData_MEM(wd_o), .BranchTarget_MEM(tgt_o), .RD_MEM(rd_o), .pc_MEM(pc_o)
  );

  assign act = '{rw: rw_o, br: br_o, ub: ub_o, mr: mr_o, mw: mw_o, m2r: m2r_o,
                 bt: bt_o, z: z_o, alu: alu_o, wd: wd_o, tgt: tgt_o, rd: rd_o, pc: pc_o};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // What the EX/MEM register must hold after an unstalled, unflushed edge
  function automatic out_t model();
    out_t        o;
    logic [63:0] opb, res;
    opb = src_i ? imm_i : b_i;
    case (op_i)
      4'd0:    res = a_i & opb;
      4'd1:    res = a_i | opb;
      4'd2:    res = a_i + opb;
      4'd6:    res = a_i - opb;
      4'd7:    res = opb;
      default: res = 64'd0;
    endcase
    o.rw  = rw_i;  o.br = br_i;  o.ub = ub_i;  o.mr = mr_i;
    o.mw  = mw_i;  o.m2r = m2r_i;
    o.z   = (res == 64'd0);
    o.bt  = ub_i || (br_i && o.z);
    o.alu = res;
    o.wd  = b_i;
    o.tgt = pc_i + imm_i * 64'd4;
    o.rd  = rd_i;
    o.pc  = pc_i;
    return o;
  endfunction

  task automatic compare(input string nm);
    checks++;
    if (act !== exp_q) begin
      failures++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp_q);
    end
  endtask

  // Pins one DUT field and the matching model field to a hand-derived value
  task automatic lit(input string nm, input logic [63:0] dut_v,
                     input logic [63:0] mdl_v, input logic [63:0] want);
    checks += 2;
    if (dut_v !== want) begin
      failures++;
      $display("FAIL %s dut=%h want=%h", nm, dut_v, want);
    end
    if (mdl_v !== want) begin
      failures++;
      $display("FAIL model_%s model=%h want=%h", nm, mdl_v, want);
    end
  endtask

  task automatic clr_in();
    stall = 0; flush = 0;
    rw_i = 0; src_i = 0; br_i = 0; ub_i = 0; mr_i = 0; mw_i = 0; m2r_i = 0;
    op_i = 4'd0; rd_i = 5'd0; a_i = 0; b_i = 0; imm_i = 0; pc_i = 0;
  endtask

  // Advance one edge with the currently driven inputs, then check
  task automatic cycle(input string nm);
    if (flush) exp_q = '0;
    else if (!stall) exp_q = model();
    @(posedge clk);
    @(negedge clk);
    compare(nm);
  endtask

  localparam logic [3:0] OPS [8] = '{4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd3, 4'd5, 4'd15};

  initial begin
    checks = 0; failures = 0;
    clr_in();
    resetl = 1'b0;
    exp_q  = '0;
    repeat (2) @(negedge clk);
    compare("reset");
    resetl = 1'b1;

    // ADD
    clr_in(); a_i = 5; b_i = 7; op_i = 4'b0010; rd_i = 3; rw_i = 1;
    cycle("add");
    lit("add_alu", act.alu, exp_q.alu, 64'd12);
    lit("add_zero", 64'(act.z), 64'(exp_q.z), 64'd0);
    lit("add_rd", 64'(act.rd), 64'(exp_q.rd), 64'd3);
    lit("add_rw", 64'(act.rw), 64'(exp_q.rw), 64'd1);
    lit("add_bt", 64'(act.bt), 64'(exp_q.bt), 64'd0);

    // LDUR address
    clr_in(); a_i = 64'h100; imm_i = 64'h8; src_i = 1; op_i = 4'b0010; mr_i = 1; m2r_i = 1;
    cycle("ldur");
    lit("ldur_alu", act.alu, exp_q.alu, 64'h108);
    lit("ldur_mr", 64'(act.mr), 64'(exp_q.mr), 64'd1);

    // SUB to zero
    clr_in(); a_i = 9; b_i = 9; op_i = 4'b0110;
    cycle("sub");
    lit("sub_alu", act.alu, exp_q.alu, 64'd0);
    lit("sub_zero", 64'(act.z), 64'(exp_q.z), 64'd1);

    // CBZ backward, taken then not taken
    clr_in(); pc_i = 64'h40; imm_i = 64'hFFFF_FFFF_FFFF_FFFC; b_i = 0; op_i = 4'b0111; br_i = 1;
    cycle("cbz_t");
    lit("cbz_tgt", act.tgt, exp_q.tgt, 64'h30);
    lit("cbz_zero", 64'(act.z), 64'(exp_q.z), 64'd1);
    lit("cbz_bt", 64'(act.bt), 64'(exp_q.bt), 64'd1);
    b_i = 1;
    cycle("cbz_nt");
    lit("cbz_nt_bt", 64'(act.bt), 64'(exp_q.bt), 64'd0);

    // B
    clr_in(); ub_i = 1; pc_i = 8; imm_i = 3;
    cycle("b");
    lit("b_tgt", act.tgt, exp_q.tgt, 64'h14);
    lit("b_bt", 64'(act.bt), 64'(exp_q.bt), 64'd1);

    // Stall holds, release loads, flush beats stall
    clr_in(); a_i = 5; b_i = 7; op_i = 4'b0010; rw_i = 1;
    cycle("st_load");
    a_i = 1; b_i = 2; op_i = 4'b0001; stall = 1;
    cycle("stall1");
    cycle("stall2");
    lit("stall_alu", act.alu, exp_q.alu, 64'd12);
    stall = 0;
    cycle("unstall");
    lit("unstall_alu", act.alu, exp_q.alu, 64'd3);
    stall = 1; flush = 1; mw_i = 1; mr_i = 1; br_i = 1; ub_i = 1;
    cycle("flush");
    lit("flush_ctl", 64'({act.rw, act.br, act.ub, act.mr, act.mw, act.m2r, act.bt}),
        64'({exp_q.rw, exp_q.br, exp_q.ub, exp_q.mr, exp_q.mw, exp_q.m2r, exp_q.bt}), 64'd0);
    lit("flush_alu", act.alu, exp_q.alu, 64'd0);

    // Async reset between edges, then first edge loads normally
    clr_in(); a_i = 5; b_i = 7; op_i = 4'b0010; rw_i = 1; rd_i = 5'd31;
    cycle("pre_rst");
    lit("xzr_rd", 64'(act.rd), 64'(exp_q.rd), 64'd31);
    #2 resetl = 1'b0; exp_q = '0;
    #1 compare("async_rst");
    lit("rst_rw", 64'(act.rw), 64'(exp_q.rw), 64'd0);
    #1 resetl = 1'b1;
    a_i = 20; b_i = 22;
    cycle("post_rst");
    lit("post_rst_alu", act.alu, exp_q.alu, 64'd42);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      stall = ($urandom_range(0, 4) == 0);
      flush = ($urandom_range(0, 7) == 0);
      rw_i = 1'($urandom); src_i = 1'($urandom); br_i = 1'($urandom);
      ub_i = ($urandom_range(0, 3) == 0); mr_i = 1'($urandom);
      mw_i = 1'($urandom); m2r_i = 1'($urandom);
      op_i = OPS[$urandom_range(0, 7)];
      rd_i = 5'($urandom);
      a_i  = {$urandom, $urandom};
      b_i  = ($urandom_range(0, 3) == 0) ? a_i : {$urandom, $urandom};
      if ($urandom_range(0, 5) == 0) b_i = 64'd0;
      imm_i = ($urandom_range(0, 1) == 1) ? 64'($signed(12'($urandom))) : {$urandom, $urandom};
      pc_i  = {$urandom, $urandom};
      cycle("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
